// File: rtl/sha_1_pad.sv
// rtl/sha_1_pad.sv - SHA-1 message padder: packs 32-bit words into 512-bit blocks with 0x80 marker and 64-bit length
module sha_1_pad (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  In_Data,
    input  logic         In_Valid,
    input  logic         In_Last,
    input  logic [2:0]   In_Bytes,
    output logic         In_Ready,
    output logic [511:0] Data,
    output logic [63:0]  Index,
    output logic         Enable,
    input  logic         Ready,
    output logic         Done
);

    typedef enum logic [1:0] {COLLECT, PAD, SEND, WAIT} state_t;

    state_t      state;
    logic [3:0]  wcnt;
    logic [63:0] byte_cnt;
    logic        pend_80;    // last word was full, 0x80 still owed
    logic        len_here;   // 0x80 sits at word <= 13 of this block, so length fits here
    logic        padding;
    logic        final_blk;

    logic [2:0]  n_bytes;
    logic [63:0] bit_len;
    logic [31:0] pad_word;
    logic [8:0]  wsel;

    assign n_bytes  = (In_Bytes > 3'd4) ? 3'd4 : In_Bytes;
    assign bit_len  = {byte_cnt[60:0], 3'b000};
    assign wsel     = {wcnt, 5'b00000};
    assign In_Ready = (state == COLLECT);

    function automatic logic [31:0] mark_end(input logic [31:0] d, input logic [2:0] n);
        case (n)
            3'd0:    mark_end = 32'h8000_0000;
            3'd1:    mark_end = {d[31:24], 24'h80_0000};
            3'd2:    mark_end = {d[31:16], 16'h8000};
            default: mark_end = {d[31:8], 8'h80};
        endcase
    endfunction

    always_comb begin
        pad_word = 32'h0;
        if (pend_80)
            pad_word = 32'h8000_0000;
        else if (len_here && wcnt == 4'd14)
            pad_word = bit_len[63:32];
        else if (len_here && wcnt == 4'd15)
            pad_word = bit_len[31:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= COLLECT;
            wcnt      <= 4'd0;
            byte_cnt  <= 64'd0;
            pend_80   <= 1'b0;
            len_here  <= 1'b0;
            padding   <= 1'b0;
            final_blk <= 1'b0;
            Data      <= '0;
            Index     <= 64'd0;
            Enable    <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Enable <= 1'b0;
            Done   <= 1'b0;
            case (state)
                COLLECT: begin
                    if (In_Valid) begin
                        wcnt <= wcnt + 4'd1;
                        if (In_Last) begin
                            byte_cnt <= byte_cnt + 64'(n_bytes);
                            padding  <= 1'b1;
                            if (n_bytes == 3'd4) begin
                                Data[wsel +: 32] <= In_Data;
                                pend_80          <= 1'b1;
                            end else begin
                                Data[wsel +: 32] <= mark_end(In_Data, n_bytes);
                                // marker at word 15 pushes the length into a fresh block
                                len_here         <= (wcnt != 4'd14);
                            end
                            if (wcnt == 4'd15) begin
                                state  <= SEND;
                                Enable <= 1'b1;
                            end else begin
                                state  <= PAD;
                            end
                        end else begin
                            byte_cnt         <= byte_cnt + 64'd4;
                            Data[wsel +: 32] <= In_Data;
                            if (wcnt == 4'd15) begin
                                state  <= SEND;
                                Enable <= 1'b1;
                            end
                        end
                    end
                end
                PAD: begin
                    Data[wsel +: 32] <= pad_word;
                    wcnt             <= wcnt + 4'd1;
                    if (pend_80) begin
                        pend_80  <= 1'b0;
                        len_here <= (wcnt <= 4'd13);
                    end
                    if (wcnt == 4'd15) begin
                        state  <= SEND;
                        Enable <= 1'b1;
                        if (pend_80 || !len_here)
                            len_here  <= 1'b1;
                        else
                            final_blk <= 1'b1;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (Ready) begin
                        wcnt <= 4'd0;
                        if (final_blk) begin
                            Done      <= 1'b1;
                            Index     <= 64'd0;
                            byte_cnt  <= 64'd0;
                            final_blk <= 1'b0;
                            padding   <= 1'b0;
                            len_here  <= 1'b0;
                            state     <= COLLECT;
                        end else begin
                            Index <= Index + 64'd1;
                            state <= padding ? PAD : COLLECT;
                        end
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_1_pad.sv
// tb/tb_sha_1_pad.sv - directed self-checking bench for sha_1_pad
module tb_sha_1_pad;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  In_Data;
    logic         In_Valid;
    logic         In_Last;
    logic [2:0]   In_Bytes;
    logic         In_Ready;
    logic [511:0] Data;
    logic [63:0]  Index;
    logic         Enable;
    logic         Ready;
    logic         Done;

    sha_1_pad dut (
        .clk      (clk),
        .rst      (rst),
        .In_Data  (In_Data),
        .In_Valid (In_Valid),
        .In_Last  (In_Last),
        .In_Bytes (In_Bytes),
        .In_Ready (In_Ready),
        .Data     (Data),
        .Index    (Index),
        .Enable   (Enable),
        .Ready    (Ready),
        .Done     (Done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [31:0] in_words [17];
    int          n_words;
    logic [2:0]  last_bytes;
    logic [31:0] ew [2][16];
    int          n_blk;

    always @(negedge clk) if (Done) done_cnt++;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] g(input int k);
        logic [7:0] b;
        b = 8'h61 + 8'(k);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    function automatic logic [511:0] pack(input int b);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[i*32 +: 32] = ew[b][i];
        return r;
    endfunction

    task automatic clear_exp();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 16; i++) ew[b][i] = 32'h0;
    endtask

    task automatic drive_msg(input bit hold);
        for (int i = 0; i < n_words; i++) begin
            int t;
            @(negedge clk);
            In_Data  = in_words[i];
            In_Last  = (i == n_words - 1);
            In_Bytes = (i == n_words - 1) ? last_bytes : 3'd0;
            In_Valid = 1'b1;
            t = 0;
            while (!In_Ready && t < 300) begin
                @(negedge clk);
                t++;
            end
            if (t >= 300) check("drive_timeout", 1, 0);
            @(posedge clk);
            if (!hold) begin
                @(negedge clk);
                In_Valid = 1'b0;
            end
        end
        @(negedge clk);
        In_Valid = 1'b0;
        In_Last  = 1'b0;
    endtask

    task automatic check_blocks(input string tag);
        for (int b = 0; b < n_blk; b++) begin
            int t;
            logic [511:0] snap;
            t = 0;
            @(negedge clk);
            while (!Enable && t < 500) begin
                @(negedge clk);
                t++;
            end
            check({tag, "_enable"}, Enable, 1);
            check({tag, "_data"}, Data, pack(b));
            check({tag, "_index"}, Index, 64'(b));
            snap = Data;
            @(negedge clk);
            check({tag, "_enable_1cyc"}, Enable, 0);
            repeat (3) @(negedge clk);
            check({tag, "_hold_data"}, Data, snap);
            check({tag, "_hold_ready"}, In_Ready, 0);
            Ready = 1'b1;
            @(negedge clk);
            Ready = 1'b0;
            if (b == n_blk - 1) begin
                check({tag, "_done"}, Done, 1);
                check({tag, "_index_clr"}, Index, 0);
                @(negedge clk);
                check({tag, "_done_1cyc"}, Done, 0);
            end else begin
                check({tag, "_nodone"}, Done, 0);
                check({tag, "_index_inc"}, Index, 64'(b + 1));
            end
        end
    endtask

    task automatic run_msg(input string tag, input bit hold);
        int d0;
        d0 = done_cnt;
        fork
            drive_msg(hold);
            check_blocks(tag);
        join
        check({tag, "_done_count"}, done_cnt - d0, 1);
    endtask

    task automatic setup_abc();
        in_words[0] = 32'h6162_6300;
        n_words = 1; last_bytes = 3'd3; n_blk = 1;
        clear_exp();
        ew[0][0]  = 32'h6162_6380;
        ew[0][15] = 32'h0000_0018;
    endtask

    initial begin
        rst = 1'b0; In_Data = '0; In_Valid = 1'b0; In_Last = 1'b0; In_Bytes = '0; Ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_data", Data, 0);
        check("rst_index", Index, 0);
        check("rst_enable", Enable, 0);
        check("rst_done", Done, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", In_Ready, 1);

        Ready = 1'b1;
        @(negedge clk);
        Ready = 1'b0;
        check("stray_ready_index", Index, 0);
        check("stray_ready_done", Done, 0);
        check("stray_ready_in_ready", In_Ready, 1);

        setup_abc();
        run_msg("abc", 1'b0);

        in_words[0] = 32'hdead_beef;
        n_words = 1; last_bytes = 3'd0; n_blk = 1;
        clear_exp();
        ew[0][0] = 32'h8000_0000;
        run_msg("empty", 1'b0);

        n_words = 14; last_bytes = 3'd4; n_blk = 2;
        clear_exp();
        for (int i = 0; i < 14; i++) begin in_words[i] = g(i); ew[0][i] = g(i); end
        ew[0][14] = 32'h8000_0000;
        ew[1][15] = 32'h0000_01C0;
        run_msg("msg56", 1'b0);

        n_words = 14; last_bytes = 3'd3; n_blk = 1;
        clear_exp();
        for (int i = 0; i < 14; i++) begin in_words[i] = g(i); ew[0][i] = g(i); end
        ew[0][13] = 32'h6e6f_7080;
        ew[0][15] = 32'h0000_01B8;
        run_msg("msg55", 1'b0);

        n_words = 16; last_bytes = 3'd4; n_blk = 2;
        clear_exp();
        for (int i = 0; i < 16; i++) begin in_words[i] = g(i); ew[0][i] = g(i); end
        ew[1][0]  = 32'h8000_0000;
        ew[1][15] = 32'h0000_0200;
        run_msg("msg64", 1'b0);

        n_words = 16; last_bytes = 3'd2; n_blk = 2;
        clear_exp();
        for (int i = 0; i < 16; i++) begin in_words[i] = g(i); ew[0][i] = g(i); end
        ew[0][15] = 32'h7071_8000;
        ew[1][15] = 32'h0000_01F0;
        run_msg("msg62", 1'b0);

        n_words = 17; last_bytes = 3'd7; n_blk = 2;
        clear_exp();
        for (int i = 0; i < 17; i++) in_words[i] = g(i);
        for (int i = 0; i < 16; i++) ew[0][i] = g(i);
        ew[1][0]  = 32'h7172_7374;
        ew[1][1]  = 32'h8000_0000;
        ew[1][15] = 32'h0000_0220;
        run_msg("msg68_hold", 1'b1);

        begin
            int t;
            int d0;
            d0 = done_cnt;
            setup_abc();
            drive_msg(1'b0);
            t = 0;
            while (!Enable && t < 500) begin
                @(negedge clk);
                t++;
            end
            check("rstwait_enable", Enable, 1);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check("rstwait_enable0", Enable, 0);
            check("rstwait_index", Index, 0);
            check("rstwait_data", Data, 0);
            rst = 1'b1;
            Ready = 1'b1;
            @(negedge clk);
            Ready = 1'b0;
            repeat (2) @(negedge clk);
            check("rstwait_no_done", done_cnt - d0, 0);
            check("rstwait_in_ready", In_Ready, 1);
        end

        setup_abc();
        run_msg("abc_after_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
